// File: rtl/vx_benes_route_3.sv
// Benes 3-lane permute control generator: checks a source map, derives {c2,c1,c0}
// and buffers {data, control} in a 2-entry FIFO. Optional legality check: VX_BENES_ROUTE_CHECK_EN.
module vx_benes_route_3 #(
  parameter int DEPTH = 2,
  parameter int ERRW  = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_data,
  input  logic [5:0]      req_src,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [2:0]      rsp_data,
  output logic [2:0]      rsp_control,
  output logic            err_pulse,
  output logic [ERRW-1:0] err_count
);

  localparam logic [1:0] FULL = DEPTH[1:0];

  logic [5:0] mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;

  logic [1:0] s2, s1, s0;
  logic [2:0] control;
  logic       accept;
  logic       push;
  logic       pop;

  assign s2 = req_src[5:4];
  assign s1 = req_src[3:2];
  assign s0 = req_src[1:0];

  // Control comes straight from the source fields, legal map or not.
  assign control = {s2 != 2'd2, s2 == 2'd0, s1 < s0};

  assign req_ready = (count != FULL);
  assign rsp_valid = (count != 2'd0);
  assign accept    = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;

  assign {rsp_data, rsp_control} = mem[rd_ptr];

`ifdef VX_BENES_ROUTE_CHECK_EN
  logic legal;

  assign legal = (s2 <= 2'd2) && (s1 <= 2'd2) && (s0 <= 2'd2) &&
                 (s2 != s1) && (s2 != s0) && (s1 != s0);
  assign push  = accept && legal;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= accept && !legal;
      if (accept && !legal && (err_count != {ERRW{1'b1}}))
        err_count <= err_count + 1'b1;
    end
  end
`else
  assign push      = accept;
  assign err_pulse = 1'b0;
  assign err_count = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: storage is reset so the head outputs read 0 the moment reset asserts.
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {req_data, control};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_vx_benes_route_3.sv
// Self-checking bench for vx_benes_route_3: queue-based FIFO model with a
// table-driven control reference; follows VX_BENES_ROUTE_CHECK_EN like the DUT.
module tb_vx_benes_route_3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_data;
  logic [5:0] req_src;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [2:0] rsp_data;
  logic [2:0] rsp_control;
  logic       err_pulse;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

`ifdef VX_BENES_ROUTE_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  // Model state: expected FIFO contents {data, control} and error indications.
  logic [5:0] mq [$];
  bit         m_errp = 1'b0;
  int         m_errc = 0;

  // Required encodings, (s2,s1,s0) -> {c2,c1,c0}.
  logic [5:0] map_tab  [6] = '{6'b10_01_00, 6'b10_00_01, 6'b01_10_00,
                               6'b01_00_10, 6'b00_10_01, 6'b00_01_10};
  logic [2:0] ctrl_tab [6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};

  vx_benes_route_3 #(.DEPTH(2), .ERRW(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_src(req_src),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_control(rsp_control),
    .err_pulse(err_pulse), .err_count(err_count)
  );

  always #5 clk = ~clk;

  function automatic bit is_legal(input logic [5:0] s);
    int a, b, c;
    a = int'(s[5:4]); b = int'(s[3:2]); c = int'(s[1:0]);
    return (a <= 2) && (b <= 2) && (c <= 2) && (a != b) && (a != c) && (b != c);
  endfunction

  function automatic logic [2:0] ref_ctrl(input logic [5:0] s);
    int a, b, c;
    if (is_legal(s)) begin
      for (int i = 0; i < 6; i++)
        if (map_tab[i] == s) return ctrl_tab[i];
    end
    a = int'(s[5:4]); b = int'(s[3:2]); c = int'(s[1:0]);
    return {a != 2, a == 0, b < c};
  endfunction

  // Applies a legal map: out[k] = in[s_k].
  function automatic logic [2:0] permute(input logic [2:0] d, input logic [5:0] s);
    logic [2:0] o;
    for (int k = 0; k < 3; k++) o[k] = d[s[2*k +: 2]];
    return o;
  endfunction

  function automatic logic [5:0] map_of_ctrl(input logic [2:0] c);
    for (int i = 0; i < 6; i++)
      if (ctrl_tab[i] == c) return map_tab[i];
    return 6'b11_11_11;
  endfunction

  function automatic logic [5:0] rand_legal();
    return map_tab[$urandom_range(0, 5)];
  endfunction

  // Drives one cycle of inputs, then advances the model across the edge.
  task automatic tick(input bit v, input logic [2:0] d, input logic [5:0] s, input bit rr);
    bit acc, pop;
    req_valid = v; req_data = d; req_src = s; rsp_ready = rr;
    @(posedge clk);
    acc = v && (mq.size() != 2);
    pop = (mq.size() != 0) && rr;
    if (pop) void'(mq.pop_front());
    m_errp = 1'b0;
    if (acc) begin
      if (!CHECK_EN || is_legal(s)) mq.push_back({d, ref_ctrl(s)});
      else begin
        m_errp = 1'b1;
        if (m_errc < 255) m_errc++;
      end
    end
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 4 && mq.size() != 0; i++) tick(1'b0, 3'b0, 6'b0, 1'b1);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = 1'b0; req_data = '0; req_src = '0; rsp_ready = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    checks++; if ({rsp_data, rsp_control} !== 6'b0) begin errors++; $display("FAIL reset_head got %b want 0", {rsp_data, rsp_control}); end
    checks++; if (err_pulse !== 1'b0 || err_count !== 8'd0) begin errors++; $display("FAIL reset_err got %b/%0d want 0/0", err_pulse, err_count); end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_legal_maps();
    logic [2:0] d, got_out, exp_out;
    for (int i = 0; i < 6; i++) begin
      d = 3'b001 << $urandom_range(0, 2);
      tick(1'b1, d, map_tab[i], 1'b1);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_control !== ctrl_tab[i] || rsp_data !== d) begin
        errors++;
        $display("FAIL legal_map_%0d got v=%b c=%b d=%b want v=1 c=%b d=%b", i, rsp_valid, rsp_control, rsp_data, ctrl_tab[i], d);
      end
      exp_out = permute(d, map_tab[i]);
      got_out = permute(rsp_data, map_of_ctrl(rsp_control));
      checks++;
      if (got_out !== exp_out) begin
        errors++; $display("FAIL permute_%0d got %b want %b", i, got_out, exp_out);
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [5:0] a, b, c;
    logic [2:0] da, db, dc;
    a = rand_legal(); b = rand_legal(); c = rand_legal();
    da = 3'($urandom); db = 3'($urandom); dc = 3'($urandom);
    tick(1'b1, da, a, 1'b0);
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_first got rdy=%b v=%b want 1/1", req_ready, rsp_valid); end
    tick(1'b1, db, b, 1'b0);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_full got rdy=%b want 0", req_ready); end
    tick(1'b1, dc, c, 1'b0);
    checks++;
    if (req_ready !== 1'b0 || {rsp_data, rsp_control} !== {da, ref_ctrl(a)}) begin
      errors++; $display("FAIL bp_hold got rdy=%b head=%b want 0/%b", req_ready, {rsp_data, rsp_control}, {da, ref_ctrl(a)});
    end
    tick(1'b1, dc, c, 1'b1);
    checks++;
    if (req_ready !== 1'b1 || {rsp_data, rsp_control} !== {db, ref_ctrl(b)}) begin
      errors++; $display("FAIL bp_drain1 got rdy=%b head=%b want 1/%b", req_ready, {rsp_data, rsp_control}, {db, ref_ctrl(b)});
    end
    tick(1'b1, dc, c, 1'b1);
    checks++;
    if (rsp_valid !== 1'b1 || {rsp_data, rsp_control} !== {dc, ref_ctrl(c)}) begin
      errors++; $display("FAIL bp_third got v=%b head=%b want 1/%b", rsp_valid, {rsp_data, rsp_control}, {dc, ref_ctrl(c)});
    end
    tick(1'b0, 3'b0, 6'b0, 1'b1);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got v=%b want 0", rsp_valid); end
  endtask

  task automatic test_simultaneous();
    logic [5:0] a, b;
    logic [2:0] da, db;
    a = rand_legal(); b = rand_legal();
    da = 3'($urandom); db = 3'($urandom);
    tick(1'b1, da, a, 1'b0);
    tick(1'b1, db, b, 1'b1);
    checks++;
    if (rsp_valid !== 1'b1 || req_ready !== 1'b1 || {rsp_data, rsp_control} !== {db, ref_ctrl(b)}) begin
      errors++;
      $display("FAIL push_pop got v=%b rdy=%b head=%b want 1/1/%b", rsp_valid, req_ready, {rsp_data, rsp_control}, {db, ref_ctrl(b)});
    end
    tick(1'b0, 3'b0, 6'b0, 1'b1);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL push_pop_count got v=%b want 0", rsp_valid); end
  endtask

  task automatic test_illegal();
    if (CHECK_EN) begin
      tick(1'b1, 3'b011, {2'd1, 2'd1, 2'd0}, 1'b1);
      checks++;
      if (rsp_valid !== 1'b0 || err_pulse !== 1'b1 || err_count !== 8'd1) begin
        errors++; $display("FAIL illegal_drop got v=%b p=%b n=%0d want 0/1/1", rsp_valid, err_pulse, err_count);
      end
      tick(1'b0, 3'b0, 6'b0, 1'b1);
      checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL illegal_pulse_len got %b want 0", err_pulse); end
      for (int i = 0; i < 300; i++) tick(1'b1, 3'($urandom), {2'd3, 2'($urandom), 2'($urandom)}, 1'b1);
      checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL err_saturate got %0d want 255", err_count); end
    end else begin
      tick(1'b1, 3'b101, {2'd3, 2'd1, 2'd0}, 1'b1);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_control !== 3'b100 || rsp_data !== 3'b101) begin
        errors++; $display("FAIL nocheck_push got v=%b c=%b d=%b want 1/100/101", rsp_valid, rsp_control, rsp_data);
      end
      checks++;
      if (err_pulse !== 1'b0 || err_count !== 8'd0) begin
        errors++; $display("FAIL nocheck_err got %b/%0d want 0/0", err_pulse, err_count);
      end
    end
    drain();
  endtask

  task automatic test_random();
    logic [5:0] s;
    for (int i = 0; i < 300; i++) begin
      s = ($urandom_range(0, 3) == 0) ? 6'($urandom) : rand_legal();
      tick(1'($urandom), 3'($urandom), s, ($urandom_range(0, 2) != 0));
      checks++;
      if (rsp_valid !== (mq.size() != 0) || req_ready !== (mq.size() != 2)) begin
        errors++; $display("FAIL rand_flags_%0d got v=%b rdy=%b want count %0d", i, rsp_valid, req_ready, mq.size());
      end
      if (mq.size() != 0) begin
        checks++;
        if ({rsp_data, rsp_control} !== mq[0]) begin
          errors++; $display("FAIL rand_head_%0d got %b want %b", i, {rsp_data, rsp_control}, mq[0]);
        end
      end
      checks++;
      if (err_pulse !== m_errp || err_count !== 8'(m_errc)) begin
        errors++; $display("FAIL rand_err_%0d got %b/%0d want %b/%0d", i, err_pulse, err_count, m_errp, m_errc);
      end
    end
  endtask

  task automatic test_reset_midflight();
    drain();
    tick(1'b1, 3'b110, rand_legal(), 1'b0);
    tick(1'b1, 3'b011, rand_legal(), 1'b0);
    #2;
    req_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    mq.delete(); m_errp = 1'b0; m_errc = 0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || {rsp_data, rsp_control} !== 6'b0) begin
      errors++; $display("FAIL async_reset got v=%b rdy=%b head=%b want 0/1/0", rsp_valid, req_ready, {rsp_data, rsp_control});
    end
    checks++;
    if (err_pulse !== 1'b0 || err_count !== 8'd0) begin
      errors++; $display("FAIL async_reset_err got %b/%0d want 0/0", err_pulse, err_count);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 3'b0, 6'b0, 1'b1);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL stale_rsp_%0d got v=%b want 0", i, rsp_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_legal_maps();
    test_backpressure();
    test_simultaneous();
    test_illegal();
    test_random();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
